tl_get_arbiter: RTL and testbench
=================================

# tl_get_arbiter

Two-client TileLink-UL Get arbiter that shares one single-beat A-channel manager port, typically the input of an A/D buffer stage, between two requesters. It interleaves A requests fairly, tags each request's source with the client index, and steers multi-beat D responses back to the owning client. An optional per-client outstanding limit bounds in-flight requests.

## Interface
- MAX_OUTSTANDING, 4, maximum in-flight requests per client (1..15); used only when the limit is compiled in (see Configuration).
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- inN_a_valid / inN_a_ready (N=0,1)  input / output  1  client A handshake.
- inN_a_bits_opcode  input  3  A opcode. Only Get (4) is legal.
- inN_a_bits_size  input  4  log2 of transfer bytes.
- inN_a_bits_source  input  4  client-local source ID.
- inN_d_valid / inN_d_ready  output / input  1  client D handshake.
- inN_d_bits_opcode, _param, _size, _source, _sink, _denied, _data, _corrupt  output  3,2,4,4,1,1,64,1  D fields; source is the lower 4 bits of out_d_bits_source.
- out_a_valid / out_a_ready  output / input  1  manager A handshake.
- out_a_bits_opcode, _size  output  3,4  granted client's fields, passed through unchanged.
- out_a_bits_source  output  5  {client index, client source}.
- out_d_valid / out_d_ready  input / output  1  manager D handshake.
- out_d_bits_opcode, _param, _size, _source, _sink, _denied, _data, _corrupt  input  3,2,4,5,1,1,64,1.

## Operation
- **A arbitration:** round-robin with a 1-bit priority register `prio`, reset value 0.
  - When unlocked, the grant goes to the valid client that `prio` favours, otherwise to the other valid client.
  - out_a_valid = granted client's valid (after the outstanding gate). out_a bits are muxed from the granted client.
  - inN_a_ready = out_a_ready & grant==N. The non-granted client's ready is 0.
- **Lock:** when out_a_valid=1 and out_a_ready=0, the grant and the `lock` flag are registered. The grant is held until fire, so the bits stay stable across stall cycles even if the other client raises valid.
- **On A fire:** `prio` <= ~granted index, and `lock` clears.
- **D routing:** out_d_bits_source[4] selects the destination client.
  - inN_d_valid = out_d_valid & sel==N. All D fields are broadcast to both clients.
  - out_d_ready = selected client's d_ready.
- **Beat counting:** a 3-bit `beats_left` counter, reset value 0, tracks D responses.
  - AccessAckData (opcode 1) of size s spans (s<=3 ? 1 : 2^(min(s,6)-3)) beats, i.e. 1..8.
  - AccessAck (opcode 0) spans 1 beat.
  - The counter loads on the first beat and decrements per D fire. The last beat is when the counter is 0 after the load, or the response is single-beat.
- **Reset:** clears `prio`, `lock`, `beats_left` and the counters. While reset is high, out_a_valid, inN_a_ready, inN_d_valid and out_d_ready are forced to 0.
- **Illegal A opcode:** passed through unchanged. No checking is done.

## Timing
- A path is combinational: zero added latency, and a request can fire in the same cycle it is presented.
- D path is combinational: zero latency, no buffering.
- Sustained throughput: one A per cycle. With both clients continuously valid and out_a_ready=1, grants alternate 0,1,0,1.
- A fire and D last-beat fire for the same client in the same cycle: the outstanding count is unchanged (+1 and -1 net to 0).
- Reset asserted mid-burst: all state is abandoned. The bench must not expect remaining beats to be routed after reset.

## Configuration
- `TL_GET_ARB_OUTSTANDING_LIMIT_EN` defined:
  - Each client has a 4-bit counter, reset value 0: +1 on its A fire, -1 on its D last-beat fire.
  - A client whose count equals MAX_OUTSTANDING is treated as not valid for arbitration.
  - A locked grant is never revoked, because a locked grant implies the count was below the limit.
- Macro undefined: the counters and gating are absent, there is no limit, and MAX_OUTSTANDING is ignored.

## Test plan
- **Fairness:** both clients valid for 6 cycles with out_a_ready=1 -> out_a_bits_source[4] sequence 0,1,0,1,0,1.
- **Stall lock:** client 1 valid alone with out_a_ready=0, client 0 raises valid in cycle 2, ready rises in cycle 4 -> client 1 fires in cycle 4 with stable bits; client 0 fires in cycle 5.
- **Source tagging:** client 1 sends Get with source 4'hA and size 6 -> out_a_bits_source=5'h1A. Eight AccessAckData beats with source 5'h1A reach only in1_d, with in0_d_valid=0 throughout.
- **Backpressure:** in0_d_ready=0 during a D beat for client 0 -> out_d_ready=0, and the beat is held until ready returns.
- **Limit (macro on, MAX_OUTSTANDING=2):** client 0 issues 3 Gets with no responses -> the third request sees in0_a_ready=0. After one single-beat AccessAck returns, the third fires the next cycle.
- **Reset mid-operation:** reset during beat 3 of an 8-beat response -> all outputs 0 during reset. After release, a fresh Get from client 0 is granted first (prio=0).

Source files
------------

// File: rtl/tl_get_arbiter_if.sv
// tl_get_arbiter_if: single-beat TileLink-UL Get link (A request channel plus D response channel).
//
// Parameters:
//   SourceW - width of the A/D source fields (4 on the client side, 5 on the manager side).
// Modports:
//   master - issues A requests and consumes D responses (a_* out, d_ready out).
//   slave  - accepts A requests and produces D responses (a_ready out, d_* out).
interface tl_get_arbiter_if #(
    parameter int unsigned SourceW = 4
);
    logic               a_valid;
    logic               a_ready;
    logic [2:0]         a_bits_opcode;
    logic [3:0]         a_bits_size;
    logic [SourceW-1:0] a_bits_source;

    logic               d_valid;
    logic               d_ready;
    logic [2:0]         d_bits_opcode;
    logic [1:0]         d_bits_param;
    logic [3:0]         d_bits_size;
    logic [SourceW-1:0] d_bits_source;
    logic               d_bits_sink;
    logic               d_bits_denied;
    logic [63:0]        d_bits_data;
    logic               d_bits_corrupt;

    modport master (
        output a_valid, a_bits_opcode, a_bits_size, a_bits_source, d_ready,
        input  a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
               d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt
    );

    modport slave (
        input  a_valid, a_bits_opcode, a_bits_size, a_bits_source, d_ready,
        output a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
               d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt
    );
endinterface

// File: rtl/tl_get_arbiter.sv
// tl_get_arbiter: two-client TileLink-UL Get arbiter sharing one single-beat A/D manager port.
//
// A requests are granted round-robin (1-bit priority, held across stalls), tagged with the
// client index in source bit 4, and D responses are steered back by that bit. A beat counter
// tracks multi-beat AccessAckData responses so the last beat of each response is known.
//
// Configuration macro: TL_GET_ARB_OUTSTANDING_LIMIT_EN
//   defined   - per-client in-flight counters; a client at MAX_OUTSTANDING is not arbitrated.
//   undefined - no limit, MAX_OUTSTANDING unused.
//
// Ports:
//   clock, reset - clock and synchronous active-high reset.
//   in0, in1     - client links (slave modport, 4-bit source).
//   out          - manager link (master modport, 5-bit source = {client, client source}).
module tl_get_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input logic              clock,
    input logic              reset,
    tl_get_arbiter_if.slave  in0,
    tl_get_arbiter_if.slave  in1,
    tl_get_arbiter_if.master out
);

    if (MAX_OUTSTANDING == 0 || MAX_OUTSTANDING > 15) begin : gen_bad_max_outstanding
        $error("MAX_OUTSTANDING must be in 1..15");
    end

    logic       prio_q, prio_d;
    logic       lock_q, lock_d;
    logic       grant_q, grant_d;
    logic [2:0] beats_left_q, beats_left_d;

    logic       elig0, elig1;
    logic       grant;
    logic       a_fire;
    logic       d_sel;
    logic       d_fire;
    logic [2:0] d_beats_m1;

`ifdef TL_GET_ARB_OUTSTANDING_LIMIT_EN
    logic [3:0] cnt0_q, cnt0_d;
    logic [3:0] cnt1_q, cnt1_d;
    logic       d_last;

    assign elig0 = in0.a_valid && (cnt0_q != 4'(MAX_OUTSTANDING));
    assign elig1 = in1.a_valid && (cnt1_q != 4'(MAX_OUTSTANDING));

    // Counter 0 after a load means single-beat; otherwise the beat that takes it from 1 to 0.
    assign d_last = (beats_left_q == 3'd0) ? (d_beats_m1 == 3'd0) : (beats_left_q == 3'd1);

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (a_fire && !grant) cnt0_d = cnt0_d + 4'd1;
        if (a_fire && grant) cnt1_d = cnt1_d + 4'd1;
        if (d_fire && d_last && !d_sel) cnt0_d = cnt0_d - 4'd1;
        if (d_fire && d_last && d_sel) cnt1_d = cnt1_d - 4'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt0_q <= 4'd0;
            cnt1_q <= 4'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end
`else
    assign elig0 = in0.a_valid;
    assign elig1 = in1.a_valid;
`endif

    // A stalled grant stays locked so the presented bits cannot change until fire.
    always_comb begin
        if (lock_q) begin
            grant = grant_q;
        end else if (prio_q) begin
            grant = elig1 || !elig0;
        end else begin
            grant = !elig0 && elig1;
        end
    end

    assign out.a_valid         = ~reset & (grant ? elig1 : elig0);
    assign out.a_bits_opcode   = grant ? in1.a_bits_opcode : in0.a_bits_opcode;
    assign out.a_bits_size     = grant ? in1.a_bits_size : in0.a_bits_size;
    assign out.a_bits_source   = grant ? {1'b1, in1.a_bits_source} : {1'b0, in0.a_bits_source};
    assign a_fire              = out.a_valid & out.a_ready;
    assign in0.a_ready         = out.a_ready & out.a_valid & ~grant;
    assign in1.a_ready         = out.a_ready & out.a_valid & grant;

    assign d_sel               = out.d_bits_source[4];
    assign in0.d_valid         = ~reset & out.d_valid & ~d_sel;
    assign in1.d_valid         = ~reset & out.d_valid & d_sel;
    assign out.d_ready         = ~reset & (d_sel ? in1.d_ready : in0.d_ready);
    assign d_fire              = out.d_valid & out.d_ready;

    assign in0.d_bits_opcode   = out.d_bits_opcode;
    assign in0.d_bits_param    = out.d_bits_param;
    assign in0.d_bits_size     = out.d_bits_size;
    assign in0.d_bits_source   = out.d_bits_source[3:0];
    assign in0.d_bits_sink     = out.d_bits_sink;
    assign in0.d_bits_denied   = out.d_bits_denied;
    assign in0.d_bits_data     = out.d_bits_data;
    assign in0.d_bits_corrupt  = out.d_bits_corrupt;
    assign in1.d_bits_opcode   = out.d_bits_opcode;
    assign in1.d_bits_param    = out.d_bits_param;
    assign in1.d_bits_size     = out.d_bits_size;
    assign in1.d_bits_source   = out.d_bits_source[3:0];
    assign in1.d_bits_sink     = out.d_bits_sink;
    assign in1.d_bits_denied   = out.d_bits_denied;
    assign in1.d_bits_data     = out.d_bits_data;
    assign in1.d_bits_corrupt  = out.d_bits_corrupt;

    // Beats minus one for the response on the bus: AccessAckData of 16/32/>=64 bytes is 2/4/8.
    always_comb begin
        d_beats_m1 = 3'd0;
        if (out.d_bits_opcode == 3'd1) begin
            if (out.d_bits_size >= 4'd6) begin
                d_beats_m1 = 3'd7;
            end else if (out.d_bits_size == 4'd5) begin
                d_beats_m1 = 3'd3;
            end else if (out.d_bits_size == 4'd4) begin
                d_beats_m1 = 3'd1;
            end
        end
    end

    always_comb begin
        prio_d       = prio_q;
        lock_d       = out.a_valid & ~out.a_ready;
        grant_d      = grant;
        beats_left_d = beats_left_q;
        if (a_fire) prio_d = ~grant;
        if (d_fire) begin
            beats_left_d = (beats_left_q == 3'd0) ? d_beats_m1 : beats_left_q - 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q       <= 1'b0;
            lock_q       <= 1'b0;
            grant_q      <= 1'b0;
            beats_left_q <= 3'd0;
        end else begin
            prio_q       <= prio_d;
            lock_q       <= lock_d;
            grant_q      <= grant_d;
            beats_left_q <= beats_left_d;
        end
    end

endmodule

// File: tb/tb_tl_get_arbiter.sv
// tb_tl_get_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_tl_get_arbiter;

`ifdef TL_GET_ARB_OUTSTANDING_LIMIT_EN
    localparam int unsigned MaxOut = 2;
    localparam bit LimitEn = 1'b1;
`else
    localparam int unsigned MaxOut = 4;
    localparam bit LimitEn = 1'b0;
`endif

    logic clock;
    logic reset;
    int   tests_run;
    int   tests_failed;

    tl_get_arbiter_if #(.SourceW(4)) in0_if ();
    tl_get_arbiter_if #(.SourceW(4)) in1_if ();
    tl_get_arbiter_if #(.SourceW(5)) out_if ();

    tl_get_arbiter #(.MAX_OUTSTANDING(MaxOut)) dut (
        .clock(clock),
        .reset(reset),
        .in0  (in0_if),
        .in1  (in1_if),
        .out  (out_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic drive_req(input int c, input logic v, input logic [3:0] size,
                             input logic [3:0] src);
        if (c == 0) begin
            in0_if.a_valid = v;
            in0_if.a_bits_opcode = 3'd4;
            in0_if.a_bits_size = size;
            in0_if.a_bits_source = src;
        end else begin
            in1_if.a_valid = v;
            in1_if.a_bits_opcode = 3'd4;
            in1_if.a_bits_size = size;
            in1_if.a_bits_source = src;
        end
    endtask

    task automatic drive_d(input logic v, input logic [2:0] op, input logic [3:0] size,
                           input logic [4:0] src, input logic [63:0] data);
        out_if.d_valid = v;
        out_if.d_bits_opcode = op;
        out_if.d_bits_param = 2'd0;
        out_if.d_bits_size = size;
        out_if.d_bits_source = src;
        out_if.d_bits_sink = 1'b0;
        out_if.d_bits_denied = 1'b0;
        out_if.d_bits_data = data;
        out_if.d_bits_corrupt = 1'b0;
    endtask

    task automatic idle_all();
        drive_req(0, 1'b0, 4'd0, 4'd0);
        drive_req(1, 1'b0, 4'd0, 4'd0);
        in0_if.d_ready = 1'b0;
        in1_if.d_ready = 1'b0;
        out_if.a_ready = 1'b0;
        drive_d(1'b0, 3'd0, 4'd0, 5'd0, 64'd0);
    endtask

    // Leaves the caller just after a falling edge with reset released.
    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Response length in beats from opcode and log2 size.
    function automatic int beats_for(input logic [2:0] op, input logic [3:0] size);
        int s;
        if (op != 3'd1 || size <= 4'd3) return 1;
        s = (size > 4'd6) ? 6 : int'(size);
        return 1 << (s - 3);
    endfunction

    task automatic test_reset();
        logic [5:0] obs;
        idle_all();
        reset = 1'b1;
        @(negedge clock);
        drive_req(0, 1'b1, 4'd2, 4'd1);
        drive_req(1, 1'b1, 4'd2, 4'd2);
        out_if.a_ready = 1'b1;
        in0_if.d_ready = 1'b1;
        in1_if.d_ready = 1'b1;
        drive_d(1'b1, 3'd1, 4'd3, 5'h10, 64'h1);
        for (int i = 0; i < 2; i++) begin
            #1;
            obs = {out_if.a_valid, in0_if.a_ready, in1_if.a_ready,
                   in0_if.d_valid, in1_if.d_valid, out_if.d_ready};
            tests_run++;
            if (obs !== 6'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs_low cycle %0d: got %b want 000000", i, obs);
            end
            @(negedge clock);
        end
        idle_all();
        reset = 1'b0;
        #1;
        obs = {out_if.a_valid, in0_if.a_ready, in1_if.a_ready,
               in0_if.d_valid, in1_if.d_valid, out_if.d_ready};
        tests_run++;
        if (obs !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_idle_after_release: got %b want 000000", obs);
        end
        @(negedge clock);
    endtask

    // Both clients always valid; the previous cycle's winner gets a single-beat ack each cycle.
    task automatic test_fairness();
        logic [4:0] exp_src;
        logic [1:0] exp_rdy;
        do_reset();
        drive_req(0, 1'b1, 4'd3, 4'd3);
        drive_req(1, 1'b1, 4'd5, 4'd5);
        out_if.a_ready = 1'b1;
        in0_if.d_ready = 1'b1;
        in1_if.d_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) drive_d(1'b1, 3'd0, 4'd3, {1'((i - 1) % 2), 4'd3}, 64'd0);
            #1;
            exp_src = (i % 2 == 1) ? 5'h15 : 5'h03;
            exp_rdy = (i % 2 == 1) ? 2'b10 : 2'b01;
            tests_run++;
            if ({out_if.a_valid, out_if.a_bits_source} !== {1'b1, exp_src}) begin
                tests_failed++;
                $display("FAIL fairness_src cycle %0d: got v=%b src=%h want v=1 src=%h",
                         i, out_if.a_valid, out_if.a_bits_source, exp_src);
            end
            tests_run++;
            if ({in1_if.a_ready, in0_if.a_ready} !== exp_rdy) begin
                tests_failed++;
                $display("FAIL fairness_ready cycle %0d: got %b want %b", i,
                         {in1_if.a_ready, in0_if.a_ready}, exp_rdy);
            end
            @(negedge clock);
        end
        idle_all();
    endtask

    task automatic test_stall_lock();
        logic [8:0] exp_bits;
        logic [1:0] exp_rdy;
        do_reset();
        drive_req(1, 1'b1, 4'd2, 4'd7);
        out_if.a_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 2) drive_req(0, 1'b1, 4'd3, 4'd9);
            if (cyc == 4) out_if.a_ready = 1'b1;
            if (cyc == 5) drive_req(1, 1'b0, 4'd0, 4'd0);
            #1;
            if (cyc < 5) begin
                exp_bits = {5'h17, 4'd2};
                exp_rdy  = (cyc == 4) ? 2'b10 : 2'b00;
            end else begin
                exp_bits = {5'h09, 4'd3};
                exp_rdy  = 2'b01;
            end
            tests_run++;
            if ({out_if.a_valid, out_if.a_bits_source, out_if.a_bits_size}
                    !== {1'b1, exp_bits}) begin
                tests_failed++;
                $display("FAIL stall_lock_bits cycle %0d: got v=%b src=%h size=%0d want src=%h size=%0d",
                         cyc, out_if.a_valid, out_if.a_bits_source, out_if.a_bits_size,
                         exp_bits[8:4], exp_bits[3:0]);
            end
            tests_run++;
            if ({in1_if.a_ready, in0_if.a_ready} !== exp_rdy) begin
                tests_failed++;
                $display("FAIL stall_lock_ready cycle %0d: got %b want %b", cyc,
                         {in1_if.a_ready, in0_if.a_ready}, exp_rdy);
            end
            @(negedge clock);
        end
        idle_all();
    endtask

    task automatic test_source_tag();
        logic [63:0] data;
        do_reset();
        drive_req(1, 1'b1, 4'd6, 4'hA);
        out_if.a_ready = 1'b1;
        #1;
        tests_run++;
        if ({out_if.a_valid, out_if.a_bits_source, out_if.a_bits_size, out_if.a_bits_opcode,
             in1_if.a_ready} !== {1'b1, 5'h1A, 4'd6, 3'd4, 1'b1}) begin
            tests_failed++;
            $display("FAIL source_tag_a: got v=%b src=%h size=%0d op=%0d rdy=%b want 1 1a 6 4 1",
                     out_if.a_valid, out_if.a_bits_source, out_if.a_bits_size,
                     out_if.a_bits_opcode, in1_if.a_ready);
        end
        @(negedge clock);
        idle_all();
        in0_if.d_ready = 1'b1;
        in1_if.d_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            data = {$urandom, $urandom};
            drive_d(1'b1, 3'd1, 4'd6, 5'h1A, data);
            #1;
            tests_run++;
            if ({in0_if.d_valid, in1_if.d_valid, out_if.d_ready} !== 3'b011) begin
                tests_failed++;
                $display("FAIL source_tag_d_route beat %0d: got in0v,in1v,rdy=%b want 011",
                         b, {in0_if.d_valid, in1_if.d_valid, out_if.d_ready});
            end
            tests_run++;
            if ({in1_if.d_bits_data, in1_if.d_bits_source, in1_if.d_bits_opcode}
                    !== {data, 4'hA, 3'd1}) begin
                tests_failed++;
                $display("FAIL source_tag_d_bits beat %0d: got data=%h src=%h want data=%h src=a",
                         b, in1_if.d_bits_data, in1_if.d_bits_source, data);
            end
            @(negedge clock);
        end
        idle_all();
    endtask

    task automatic test_backpressure();
        logic [2:0] exp;
        do_reset();
        in0_if.d_ready = 1'b0;
        in1_if.d_ready = 1'b1;
        drive_d(1'b1, 3'd0, 4'd3, 5'h03, 64'hDEAD);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) in0_if.d_ready = 1'b1;
            #1;
            exp = (c == 3) ? 3'b101 : 3'b100;
            tests_run++;
            if ({in0_if.d_valid, in1_if.d_valid, out_if.d_ready} !== exp) begin
                tests_failed++;
                $display("FAIL backpressure cycle %0d: got in0v,in1v,rdy=%b want %b", c,
                         {in0_if.d_valid, in1_if.d_valid, out_if.d_ready}, exp);
            end
            @(negedge clock);
        end
        idle_all();
    endtask

`ifdef TL_GET_ARB_OUTSTANDING_LIMIT_EN
    task automatic test_limit();
        logic exp;
        do_reset();
        out_if.a_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_req(0, 1'b1, 4'd0, 4'(k + 1));
            #1;
            exp = (k < 2);
            tests_run++;
            if ({out_if.a_valid, in0_if.a_ready} !== {exp, exp}) begin
                tests_failed++;
                $display("FAIL limit_issue %0d: got v,rdy=%b%b want %b%b", k,
                         out_if.a_valid, in0_if.a_ready, exp, exp);
            end
            @(negedge clock);
        end
        in0_if.d_ready = 1'b1;
        drive_d(1'b1, 3'd0, 4'd0, 5'h01, 64'd0);
        #1;
        tests_run++;
        if ({in0_if.d_valid, out_if.d_ready, in0_if.a_ready} !== 3'b110) begin
            tests_failed++;
            $display("FAIL limit_blocked_during_ack: got dv,drdy,ardy=%b want 110",
                     {in0_if.d_valid, out_if.d_ready, in0_if.a_ready});
        end
        @(negedge clock);
        drive_d(1'b0, 3'd0, 4'd0, 5'h00, 64'd0);
        #1;
        tests_run++;
        if (in0_if.a_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL limit_release: got a_ready=%b want 1", in0_if.a_ready);
        end
        @(negedge clock);
        idle_all();
    endtask
`else
    task automatic test_no_limit();
        do_reset();
        out_if.a_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_req(0, 1'b1, 4'd0, 4'(k));
            #1;
            tests_run++;
            if ({out_if.a_valid, in0_if.a_ready} !== 2'b11) begin
                tests_failed++;
                $display("FAIL no_limit_issue %0d: got v,rdy=%b%b want 11", k,
                         out_if.a_valid, in0_if.a_ready);
            end
            @(negedge clock);
        end
        idle_all();
    endtask
`endif

    task automatic test_reset_mid();
        logic [5:0] obs;
        do_reset();
        drive_req(0, 1'b1, 4'd6, 4'd1);
        out_if.a_ready = 1'b1;
        #1;
        tests_run++;
        if (in0_if.a_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_issue: got a_ready=%b want 1", in0_if.a_ready);
        end
        @(negedge clock);
        idle_all();
        in0_if.d_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            drive_d(1'b1, 3'd1, 4'd6, 5'h01, 64'(b));
            if (b >= 2) begin
                reset = 1'b1;
                drive_req(0, 1'b1, 4'd2, 4'd4);
                drive_req(1, 1'b1, 4'd2, 4'd5);
                out_if.a_ready = 1'b1;
                in1_if.d_ready = 1'b1;
            end
            #1;
            if (b >= 2) begin
                obs = {out_if.a_valid, in0_if.a_ready, in1_if.a_ready,
                       in0_if.d_valid, in1_if.d_valid, out_if.d_ready};
                tests_run++;
                if (obs !== 6'b0) begin
                    tests_failed++;
                    $display("FAIL reset_mid_outputs beat %0d: got %b want 000000", b, obs);
                end
            end
            @(negedge clock);
        end
        reset = 1'b0;
        drive_d(1'b0, 3'd0, 4'd0, 5'd0, 64'd0);
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++;
            if ({out_if.a_valid, out_if.a_bits_source[4], in1_if.a_ready, in0_if.a_ready}
                    !== {1'b1, 1'(c), 1'(c), 1'(1 - c)}) begin
                tests_failed++;
                $display("FAIL reset_mid_regrant %0d: got v=%b idx=%b rdy=%b%b want idx=%0d",
                         c, out_if.a_valid, out_if.a_bits_source[4], in1_if.a_ready,
                         in0_if.a_ready, c);
            end
            @(negedge clock);
        end
        idle_all();
    endtask

    task automatic test_random();
        int          prio_m, hold_m, g, dc, d_left;
        int          outst[2];
        logic        pend[2];
        logic        elig[2];
        logic        dr[2];
        logic [3:0]  rsize[2];
        logic [3:0]  rsrc[2];
        int          q_c[$];
        logic [3:0]  q_size[$];
        logic [3:0]  q_src[$];
        logic        d_active, ready_m;
        logic [2:0]  d_op;
        logic [3:0]  d_size, d_src;
        logic [63:0] d_data;
        logic [1:0]  exp_rdy;
        do_reset();
        prio_m = 0;
        hold_m = -1;
        dc = 0;
        d_left = 0;
        d_active = 1'b0;
        d_op = 3'd0;
        d_size = 4'd0;
        d_src = 4'd0;
        d_data = 64'd0;
        for (int c = 0; c < 2; c++) begin
            outst[c] = 0;
            pend[c] = 1'b0;
            rsize[c] = 4'd0;
            rsrc[c] = 4'd0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                if (!pend[c] && ($urandom % 2 == 0)) begin
                    pend[c] = 1'b1;
                    rsize[c] = 4'($urandom % 9);
                    rsrc[c] = 4'($urandom % 16);
                end
                drive_req(c, pend[c], rsize[c], rsrc[c]);
            end
            ready_m = ($urandom % 4 != 0);
            out_if.a_ready = ready_m;
            if (!d_active && q_c.size() > 0 && ($urandom % 2 == 0)) begin
                dc = q_c.pop_front();
                d_size = q_size.pop_front();
                d_src = q_src.pop_front();
                d_op = ($urandom % 4 == 0) ? 3'd0 : 3'd1;
                d_left = beats_for(d_op, d_size);
                d_data = {$urandom, $urandom};
                d_active = 1'b1;
            end
            drive_d(d_active, d_op, d_size, {1'(dc), d_src}, d_data);
            dr[0] = ($urandom % 3 != 0);
            dr[1] = ($urandom % 3 != 0);
            in0_if.d_ready = dr[0];
            in1_if.d_ready = dr[1];
            #1;
            for (int c = 0; c < 2; c++) begin
                elig[c] = pend[c] && (!LimitEn || outst[c] < int'(MaxOut));
            end
            if (hold_m >= 0) g = hold_m;
            else if (elig[prio_m]) g = prio_m;
            else if (elig[1 - prio_m]) g = 1 - prio_m;
            else g = -1;
            tests_run++;
            if (out_if.a_valid !== (g >= 0)) begin
                tests_failed++;
                $display("FAIL rand_a_valid cycle %0d: got %b want %b", cyc, out_if.a_valid,
                         (g >= 0));
            end
            if (g >= 0) begin
                tests_run++;
                if ({out_if.a_bits_source, out_if.a_bits_size} !== {1'(g), rsrc[g], rsize[g]})
                begin
                    tests_failed++;
                    $display("FAIL rand_a_bits cycle %0d: got src=%h size=%0d want src=%h size=%0d",
                             cyc, out_if.a_bits_source, out_if.a_bits_size, {1'(g), rsrc[g]},
                             rsize[g]);
                end
            end
            exp_rdy = {ready_m && (g == 1), ready_m && (g == 0)};
            tests_run++;
            if ({in1_if.a_ready, in0_if.a_ready} !== exp_rdy) begin
                tests_failed++;
                $display("FAIL rand_a_ready cycle %0d: got %b want %b", cyc,
                         {in1_if.a_ready, in0_if.a_ready}, exp_rdy);
            end
            if (d_active) begin
                tests_run++;
                if ({in1_if.d_valid, in0_if.d_valid, out_if.d_ready, in0_if.d_bits_data,
                     in1_if.d_bits_data} !== {dc == 1, dc == 0, dr[dc], d_data, d_data}) begin
                    tests_failed++;
                    $display("FAIL rand_d_route cycle %0d: got in1v,in0v,rdy=%b want %b%b%b",
                             cyc, {in1_if.d_valid, in0_if.d_valid, out_if.d_ready},
                             dc == 1, dc == 0, dr[dc]);
                end
            end
            if (g >= 0 && ready_m) begin
                pend[g] = 1'b0;
                outst[g]++;
                q_c.push_back(g);
                q_size.push_back(rsize[g]);
                q_src.push_back(rsrc[g]);
                prio_m = 1 - g;
                hold_m = -1;
            end else begin
                hold_m = g;
            end
            if (d_active && dr[dc]) begin
                d_left--;
                d_data = {$urandom, $urandom};
                if (d_left == 0) begin
                    outst[dc]--;
                    d_active = 1'b0;
                end
            end
            @(negedge clock);
        end
        idle_all();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        idle_all();
        test_reset();
        test_fairness();
        test_stall_lock();
        test_source_tag();
        test_backpressure();
`ifdef TL_GET_ARB_OUTSTANDING_LIMIT_EN
        test_limit();
`else
        test_no_limit();
`endif
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
